lopd_norm_arbiter: RTL

Shared normalization engine for the floating-point datapath. Two requesters, the add/sub post-normalizer (port 0) and the int-to-float converter (port 1), submit an unnormalized 24-bit mantissa and an 8-bit biased exponent. The block arbitrates between them and drives a single leading-one position detector (24-bit LOPD instance). It left-shifts the mantissa so bit 23 is set, adjusts the exponent, and returns the result tagged with the requester ID. The block is a 2-stage pipeline with valid/ready handshakes on both sides.

---
 rtl/lopd_norm_arbiter.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/lopd_norm_arbiter.sv
// Two-requester mantissa normalizer: arbiter, 24-bit leading-one position detector, 2-stage pipeline.
// Define LOPD_NORM_RR_EN for round-robin arbitration; otherwise port 0 wins every tie.

module lopd_norm_lopd24 #(
    parameter int SIZE_DATA = 24,
    parameter int SIZE_LOPD = 5
) (
    input  logic [SIZE_DATA-1:0] i_data,
    output logic [SIZE_LOPD-1:0] o_one_position,
    output logic                 o_zero
);
    localparam int NIBS = SIZE_DATA / 4;

    logic [SIZE_LOPD-1:0] w_pos;

    function automatic logic [1:0] nib_lz(input logic [3:0] n);
        logic [1:0] r;
        casez (n)
            4'b1???: r = 2'd0;
            4'b01??: r = 2'd1;
            4'b001?: r = 2'd2;
            4'b0001: r = 2'd3;
            default: r = 2'd0;
        endcase
        return r;
    endfunction

    // Walk nibbles from LSB upward so the most significant non-zero nibble decides.
    always_comb begin
        w_pos = {SIZE_LOPD{1'b0}};
        for (int j = 0; j < NIBS; j++) begin
            w_pos = (i_data[j*4 +: 4] != 4'h0)
                  ? SIZE_LOPD'(4 * (NIBS - 1 - j)) + {{(SIZE_LOPD-2){1'b0}}, nib_lz(i_data[j*4 +: 4])}
                  : w_pos;
        end
    end

    assign o_one_position = w_pos;
    assign o_zero         = (i_data == {SIZE_DATA{1'b0}});
endmodule

module lopd_norm_arbiter #(
    parameter int SIZE_DATA = 24,
    parameter int SIZE_EXP  = 8,
    parameter int SIZE_LOPD = 5
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [1:0]             i_req_valid,
    output logic [1:0]             o_req_ready,
    input  logic [2*SIZE_DATA-1:0] i_req_mant,
    input  logic [2*SIZE_EXP-1:0]  i_req_exp,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic                   o_id,
    output logic [SIZE_DATA-1:0]   o_mant,
    output logic [SIZE_EXP-1:0]    o_exp,
    output logic                   o_zero,
    output logic                   o_underflow
);
    logic                 w_adv1;
    logic                 w_adv2;
    logic [1:0]           w_grant;
    logic [1:0]           w_ready;
    logic                 w_gid;
    logic                 w_xfer;

    logic                 r_s1_valid;
    logic                 r_s1_id;
    logic [SIZE_DATA-1:0] r_s1_mant;
    logic [SIZE_EXP-1:0]  r_s1_exp;

    logic [SIZE_LOPD-1:0] w_lzc;
    logic [SIZE_EXP-1:0]  w_lzc_ext;
    logic                 w_lopd_zero;
    logic [SIZE_DATA-1:0] w_norm_mant;
    logic [SIZE_EXP-1:0]  w_norm_exp;
    logic                 w_norm_zero;
    logic                 w_norm_udf;

    logic                 r_valid;
    logic                 r_id;
    logic [SIZE_DATA-1:0] r_mant;
    logic [SIZE_EXP-1:0]  r_exp;
    logic                 r_zero;
    logic                 r_udf;

    assign w_adv2 = ~r_valid | i_ready;
    assign w_adv1 = ~r_s1_valid | w_adv2;

`ifdef LOPD_NORM_RR_EN
    logic r_ptr;

    // Round-robin grant: a tie goes to the port the pointer names.
    always_comb begin
        w_grant = 2'b00;
        if (i_req_valid == 2'b11) begin
            w_grant = r_ptr ? 2'b10 : 2'b01;
        end else begin
            w_grant = i_req_valid;
        end
    end

    // Pointer moves to the opposite port only when a transfer happens.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ptr <= 1'b0;
        end else if (w_xfer) begin
            r_ptr <= ~w_gid;
        end
    end
`else
    assign w_grant = {i_req_valid[1] & ~i_req_valid[0], i_req_valid[0]};
`endif

    assign w_ready     = (i_rst | ~w_adv1) ? 2'b00 : w_grant;
    assign o_req_ready = w_ready;
    assign w_xfer      = |(i_req_valid & w_ready);
    assign w_gid       = w_grant[1];

    // Stage 1: capture the granted request whenever the pipeline can advance.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s1_valid <= 1'b0;
            r_s1_id    <= 1'b0;
            r_s1_mant  <= {SIZE_DATA{1'b0}};
            r_s1_exp   <= {SIZE_EXP{1'b0}};
        end else if (w_adv1) begin
            r_s1_valid <= w_xfer;
            r_s1_id    <= w_gid;
            r_s1_mant  <= w_gid ? i_req_mant[SIZE_DATA +: SIZE_DATA] : i_req_mant[0 +: SIZE_DATA];
            r_s1_exp   <= w_gid ? i_req_exp[SIZE_EXP +: SIZE_EXP] : i_req_exp[0 +: SIZE_EXP];
        end
    end

    lopd_norm_lopd24 #(
        .SIZE_DATA (SIZE_DATA),
        .SIZE_LOPD (SIZE_LOPD)
    ) u_lopd (
        .i_data         (r_s1_mant),
        .o_one_position (w_lzc),
        .o_zero         (w_lopd_zero)
    );

    assign w_lzc_ext = {{(SIZE_EXP-SIZE_LOPD){1'b0}}, w_lzc};

    // Normalize: the exponent subtract only runs when the compare proves it cannot wrap.
    always_comb begin
        w_norm_mant = r_s1_mant << w_lzc;
        w_norm_exp  = {SIZE_EXP{1'b0}};
        w_norm_zero = 1'b0;
        w_norm_udf  = 1'b0;
        if (w_lopd_zero) begin
            w_norm_mant = {SIZE_DATA{1'b0}};
            w_norm_zero = 1'b1;
        end else if (r_s1_exp > w_lzc_ext) begin
            w_norm_exp = r_s1_exp - w_lzc_ext;
        end else begin
            w_norm_udf = 1'b1;
        end
    end

    // Stage 2: output register, held while the consumer stalls.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_valid <= 1'b0;
            r_id    <= 1'b0;
            r_mant  <= {SIZE_DATA{1'b0}};
            r_exp   <= {SIZE_EXP{1'b0}};
            r_zero  <= 1'b0;
            r_udf   <= 1'b0;
        end else if (w_adv2) begin
            r_valid <= r_s1_valid;
            r_id    <= r_s1_id;
            r_mant  <= w_norm_mant;
            r_exp   <= w_norm_exp;
            r_zero  <= w_norm_zero;
            r_udf   <= w_norm_udf;
        end
    end

    assign o_valid     = r_valid;
    assign o_id        = r_id;
    assign o_mant      = r_mant;
    assign o_exp       = r_exp;
    assign o_zero      = r_zero;
    assign o_underflow = r_udf;
endmodule
